// File: rtl/mcpu_bus_arbiter.sv
// Shares the MCPU external memory bus between the CPU core and the loader port.
// Build option ARB_ROUND_ROBIN_EN: contended grants alternate; otherwise the loader has fixed priority.
module mcpu_bus_arbiter #(
  parameter int AW          = 6,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_oe,
  output logic          mem_we,
  output logic          mem_drive,
  output logic          owner,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata stable; fields are
  // sampled only in IDLE, and ack pulses for exactly the RECOVER cycle of
  // that requester's transaction. A req still high in IDLE is a new request.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic          r_cpu_ack;
  logic          r_ldr_ack;
  logic          r_oe;
  logic          r_mwe;
  logic          r_drive;

  logic          w_any_req;
  logic          w_grant_ldr;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_any_req = cpu_req | ldr_req;
`ifdef ARB_ROUND_ROBIN_EN
  // On contention the bus goes to whoever did not own it last.
  assign w_grant_ldr = (cpu_req & ldr_req) ? ~r_owner : ldr_req;
`else
  assign w_grant_ldr = ldr_req;
`endif
  assign w_sel_we    = w_grant_ldr ? ldr_we    : cpu_we;
  assign w_sel_addr  = w_grant_ldr ? ldr_addr  : cpu_addr;
  assign w_sel_wdata = w_grant_ldr ? ldr_wdata : cpu_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_oe        <= 1'b0;
      r_mwe       <= 1'b0;
      r_drive     <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_ldr_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant_ldr;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= WS;
            r_oe    <= ~w_sel_we;
            r_mwe   <= w_sel_we;
            r_drive <= w_sel_we;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 3'd0) begin
            if (!r_we) begin
              if (r_owner) r_ldr_rdata <= mem_rdata;
              else         r_cpu_rdata <= mem_rdata;
            end
            // Strobes drop here so RECOVER is a clean turnaround cycle.
            r_oe      <= 1'b0;
            r_mwe     <= 1'b0;
            r_drive   <= 1'b0;
            r_cpu_ack <= ~r_owner;
            r_ldr_ack <= r_owner;
            r_state   <= S_RECOVER;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RECOVER: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign ldr_ack   = r_ldr_ack;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_oe    = r_oe;
  assign mem_we    = r_mwe;
  assign mem_drive = r_drive;
  assign owner     = r_owner;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mcpu_bus_arbiter.sv
// Bench for mcpu_bus_arbiter: transaction-timeline model, per-cycle compare, directed and random stimulus.
module tb_mcpu_bus_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int WS = 1;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] T3_GRANTS   = 4'b0101;
  localparam int         T3_CPU_ACKS = 1;
`else
  localparam logic [3:0] T3_GRANTS   = 4'b1111;
  localparam int         T3_CPU_ACKS = 0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic clk, rst_n;
  logic cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic cpu_ack, ldr_ack, mem_oe, mem_we, mem_drive, owner;
  logic [1:0] dbg_state;
  logic [DW-1:0] mem_array [64];

  logic w0_cpu_req, w0_cpu_we, w0_ldr_req, w0_ldr_we;
  logic [AW-1:0] w0_cpu_addr, w0_ldr_addr, w0_mem_addr;
  logic [DW-1:0] w0_cpu_wdata, w0_ldr_wdata, w0_cpu_rdata, w0_ldr_rdata, w0_mem_wdata, w0_mem_rdata;
  logic w0_cpu_ack, w0_ldr_ack, w0_mem_oe, w0_mem_we, w0_mem_drive, w0_owner;
  logic [1:0] w0_dbg_state;

  assign mem_rdata = mem_array[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mcpu_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_drive(mem_drive),
    .owner(owner), .dbg_state(dbg_state)
  );

  mcpu_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(w0_cpu_req), .cpu_we(w0_cpu_we), .cpu_addr(w0_cpu_addr), .cpu_wdata(w0_cpu_wdata),
    .cpu_rdata(w0_cpu_rdata), .cpu_ack(w0_cpu_ack),
    .ldr_req(w0_ldr_req), .ldr_we(w0_ldr_we), .ldr_addr(w0_ldr_addr), .ldr_wdata(w0_ldr_wdata),
    .ldr_rdata(w0_ldr_rdata), .ldr_ack(w0_ldr_ack),
    .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata), .mem_rdata(w0_mem_rdata),
    .mem_oe(w0_mem_oe), .mem_we(w0_mem_we), .mem_drive(w0_mem_drive),
    .owner(w0_owner), .dbg_state(w0_dbg_state)
  );

  // ---------------- reference model ----------------
  int n_checks, n_pass, cyc, m_start;
  bit m_busy, m_owner, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_ldr_rd;
  logic [DW-1:0] m_mem [64];
  logic [8:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // A transaction is a timeline: grant edge, WS+1 access cycles, one recover cycle.
  task automatic model_step();
    bit g;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_cpu_rd = '0; m_ldr_rd = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (cpu_req || ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        g = (cpu_req && ldr_req) ? !m_owner : ldr_req;
`else
        g = ldr_req;
`endif
        m_owner = g;
        m_we    = g ? ldr_we    : cpu_we;
        m_addr  = g ? ldr_addr  : cpu_addr;
        m_wdata = g ? ldr_wdata : cpu_wdata;
        m_busy  = 1;
        m_start = cyc;
      end
    end else if (cyc - m_start == WS + 1) begin
      if (m_we) m_mem[m_addr] = m_wdata;
      else if (m_owner) m_ldr_rd = m_mem[m_addr];
      else m_cpu_rd = m_mem[m_addr];
      exp_q.push_back({m_owner, m_owner ? m_ldr_rd : m_cpu_rd});
    end else if (cyc - m_start == WS + 2) begin
      m_busy = 0;
    end
  endtask

  task automatic compare_all();
    int ph;
    bit acc, rec;
    logic [8:0] got;
    ph  = cyc - m_start;
    acc = m_busy && (ph <= WS);
    rec = m_busy && (ph == WS + 1);
    chk("mem_oe",    32'(mem_oe),    32'(acc && !m_we));
    chk("mem_we",    32'(mem_we),    32'(acc && m_we));
    chk("mem_drive", 32'(mem_drive), 32'(acc && m_we));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("cpu_ack",   32'(cpu_ack),   32'(rec && !m_owner));
    chk("ldr_ack",   32'(ldr_ack),   32'(rec && m_owner));
    chk("owner",     32'(owner),     32'(m_owner));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    chk("ldr_rdata", 32'(ldr_rdata), 32'(m_ldr_rd));
    chk("drive_with_oe", 32'(mem_drive & mem_oe), 32'(0));
    if (cpu_ack || ldr_ack) begin
      got = {ldr_ack, ldr_ack ? ldr_rdata : cpu_rdata};
      if (exp_q.size() == 0) chk("sb_queue_on_ack", 32'(exp_q.size()), 32'(1));
      else chk("sb_rdata", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (mem_we) mem_array[mem_addr] = mem_wdata;
  endtask

  task automatic quiesce();
    cpu_req = 0; ldr_req = 0; w0_cpu_req = 0;
    repeat (6) tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  int cnt, ack_at, n_ack, ng;
  bit ok, bad, prev;
  logic [3:0] grants;
  logic [5:0] v_oe, v_we, v_dr, v_ack;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; m_start = 0;
    m_busy = 0; m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ldr_rd = '0;
    rst_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    w0_cpu_req = 0; w0_cpu_we = 0; w0_cpu_addr = '0; w0_cpu_wdata = '0;
    w0_ldr_req = 0; w0_ldr_we = 0; w0_ldr_addr = '0; w0_ldr_wdata = '0;
    w0_mem_rdata = 8'h99;
    for (int i = 0; i < 64; i++) begin
      mem_array[i] = 8'($urandom);
      m_mem[i] = mem_array[i];
    end
    tick(); tick();
    rst_n = 1;
    chk("rst_owner", 32'(owner), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);

    // CPU read of 0x2A returning 0xC3
    mem_array[6'h2A] = 8'hC3; m_mem[6'h2A] = 8'hC3;
    cpu_we = 0; cpu_addr = 6'h2A; cpu_req = 1;
    cnt = 0; ack_at = 0; ok = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (mem_oe) begin cnt++; if (mem_addr != 6'h2A) ok = 0; end
      if (cpu_ack && ack_at == 0) begin ack_at = i; cpu_req = 0; end
    end
    chk("t1_oe_cycles", cnt, 2);
    chk("t1_addr", 32'(ok), 1);
    chk("t1_ack_cycle", ack_at, 3);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'h C3);
    chk("t1_ldr_rdata", 32'(ldr_rdata), 0);

    // Loader write 0x7E to 0x05
    ldr_we = 1; ldr_addr = 6'h05; ldr_wdata = 8'h7E; ldr_req = 1;
    cnt = 0; n_ack = 0; ok = 1; bad = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (mem_we && mem_drive) begin cnt++; if (mem_wdata != 8'h7E) ok = 0; end
      if (ldr_ack) begin n_ack++; if (mem_drive) bad = 1; ldr_req = 0; end
    end
    chk("t2_we_cycles", cnt, 2);
    chk("t2_wdata", 32'(ok), 1);
    chk("t2_ack_count", n_ack, 1);
    chk("t2_drive_in_recover", 32'(bad), 0);
    chk("t2_mem_written", 32'(mem_array[5]), 32'h7E);
    chk("t2_cpu_rdata_kept", 32'(cpu_rdata), 32'hC3);
    chk("t2_ldr_rdata_kept", 32'(ldr_rdata), 0);

    // Both requesters held from a fresh reset
    rst_n = 0; tick(); rst_n = 1;
    cpu_we = 0; cpu_addr = 6'h04; ldr_we = 0; ldr_addr = 6'h03;
    cpu_req = 1; ldr_req = 1;
    ng = 0; n_ack = 0; prev = 0; grants = '0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick();
      if (cpu_ack) n_ack++;
      if ((mem_oe || mem_we) && !prev) begin grants[ng] = owner; ng++; end
      prev = mem_oe || mem_we;
    end
    chk("t3_grant_count", ng, 4);
    chk("t3_grant_order", 32'(grants), 32'(T3_GRANTS));
    chk("t3_cpu_acks", n_ack, T3_CPU_ACKS);
    quiesce();

    // Reset in the middle of a CPU read, request held through it
    mem_array[6'h11] = 8'h5A; m_mem[6'h11] = 8'h5A;
    cpu_we = 0; cpu_addr = 6'h11; cpu_req = 1;
    tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("t4_ack_after_rst", 32'(cpu_ack), 0);
    chk("t4_oe_after_rst", 32'(mem_oe), 0);
    chk("t4_addr_after_rst", 32'(mem_addr), 0);
    chk("t4_rdata_after_rst", 32'(cpu_rdata), 0);
    ack_at = 0;
    for (int i = 1; i <= 8 && ack_at == 0; i++) begin
      tick();
      if (cpu_ack) begin ack_at = i; cpu_req = 0; end
    end
    chk("t4_restart_ack_cycle", ack_at, 3);
    chk("t4_restart_rdata", 32'(cpu_rdata), 32'h5A);
    quiesce();

    // CPU read with req dropped after one ACCESS cycle
    mem_array[6'h30] = 8'hA5; m_mem[6'h30] = 8'hA5;
    cpu_we = 0; cpu_addr = 6'h30; cpu_req = 1;
    tick();
    cpu_req = 0;
    ack_at = 0;
    for (int i = 2; i <= 8 && ack_at == 0; i++) begin
      tick();
      if (cpu_ack) ack_at = i;
    end
    chk("t5_ack_cycle", ack_at, 3);
    chk("t5_rdata", 32'(cpu_rdata), 32'hA5);
    cnt = 0;
    repeat (4) begin tick(); if (mem_oe || mem_we || mem_drive) cnt++; end
    chk("t5_bus_idle", cnt, 0);

    // Zero wait states: back-to-back read then write
    w0_cpu_we = 0; w0_cpu_addr = 6'h07; w0_cpu_req = 1;
    v_oe = '0; v_we = '0; v_dr = '0; v_ack = '0; ok = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      v_oe[i] = w0_mem_oe; v_we[i] = w0_mem_we; v_dr[i] = w0_mem_drive; v_ack[i] = w0_cpu_ack;
      if (w0_mem_addr != 6'h07) ok = 0;
      if (i == 1) begin w0_cpu_we = 1; w0_cpu_wdata = 8'h3C; end
      if (i == 3 && w0_mem_wdata != 8'h3C) ok = 0;
      if (i == 4) w0_cpu_req = 0;
    end
    chk("t6_oe_pattern", 32'(v_oe), 32'(6'b000001));
    chk("t6_we_pattern", 32'(v_we), 32'(6'b001000));
    chk("t6_drive_pattern", 32'(v_dr), 32'(6'b001000));
    chk("t6_ack_pattern", 32'(v_ack), 32'(6'b010010));
    chk("t6_addr_data", 32'(ok), 1);
    chk("t6_rdata", 32'(w0_cpu_rdata), 32'h99);

    // Random traffic with occasional resets, early drops and field churn
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      if (cpu_ack) cpu_req = 0;
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 6'($urandom_range(0, 63)); cpu_wdata = 8'($urandom);
      end else if (cpu_req && m_busy && !m_owner && (cyc - m_start) <= WS && $urandom_range(0, 15) == 0)
        cpu_req = 0;
      if (ldr_ack) ldr_req = 0;
      else if (!ldr_req && $urandom_range(0, 3) == 0) begin
        ldr_req = 1; ldr_we = 1'($urandom_range(0, 1));
        ldr_addr = 6'($urandom_range(0, 63)); ldr_wdata = 8'($urandom);
      end else if (ldr_req && m_busy && m_owner && (cyc - m_start) <= WS && $urandom_range(0, 15) == 0)
        ldr_req = 0;
      if (m_busy && $urandom_range(0, 3) == 0) begin
        if (m_owner) begin ldr_addr = 6'($urandom); ldr_wdata = 8'($urandom); end
        else begin cpu_addr = 6'($urandom); cpu_wdata = 8'($urandom); end
      end
    end
    rst_n = 1;
    quiesce();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
